// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two message requesters, the transmit scheduler
// and the byte-wide UART transmitter.
interface uart_tx_sched_if #(
  parameter int unsigned MSG_BYTES = 2
);
  localparam int unsigned MSG_W = 8 * MSG_BYTES;

  logic             req0;
  logic [MSG_W-1:0] msg0;
  logic             req1;
  logic [MSG_W-1:0] msg1;
  logic             ack0;
  logic             ack1;
  logic             trmt;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             busy;
  logic             src;
  logic             msg_done;

  // master: the scheduler; slave: the requesters together with the transmitter
  modport master (
    input  req0, msg0, req1, msg1, tx_done,
    output ack0, ack1, trmt, tx_data, busy, src, msg_done
  );

  modport slave (
    output req0, msg0, req1, msg1, tx_done,
    input  ack0, ack1, trmt, tx_data, busy, src, msg_done
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that serialises fixed-length messages from two
// requesters, MS byte first, into an 8-bit UART transmitter.
module uart_tx_sched #(
  parameter int unsigned MSG_BYTES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_sched_if.master bus
);

  localparam int unsigned MSG_W = 8 * MSG_BYTES;
  localparam int unsigned CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MSG_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [MSG_W-1:0] r_msg;
  logic [MSG_W-1:0] w_msg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_src;
  logic             w_src_nxt;
  logic             r_ack0;
  logic             w_ack0_nxt;
  logic             r_ack1;
  logic             w_ack1_nxt;
  logic             r_trmt;
  logic             w_trmt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_msg_done;
  logic             w_msg_done_nxt;
  logic             w_req_any;
  logic             w_win;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last
  assign w_req_any = bus.req0 | bus.req1;
  assign w_win     = bus.req1 & (~bus.req0 | ~r_last);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_msg      <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_src      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_trmt     <= 1'b0;
      r_busy     <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_msg      <= w_msg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
      r_src      <= w_src_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_trmt     <= w_trmt_nxt;
      r_busy     <= w_busy_nxt;
      r_msg_done <= w_msg_done_nxt;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_msg_nxt      = r_msg;
    w_cnt_nxt      = r_cnt;
    w_last_nxt     = r_last;
    w_src_nxt      = r_src;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_trmt_nxt     = 1'b0;
    w_msg_done_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_msg_nxt   = w_win ? bus.msg1 : bus.msg0;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_win;
          w_src_nxt   = w_win;
          w_ack0_nxt  = ~w_win;
          w_ack1_nxt  = w_win;
          w_trmt_nxt  = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // tx_done was cleared by the edge that ended SEND, so a high here is fresh
        if (bus.tx_done) begin
          if (r_cnt == LAST_BYTE) begin
            w_msg_done_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_msg_nxt   = r_msg << 8;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_trmt_nxt  = 1'b1;
            w_state_nxt = SEND;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.trmt     = r_trmt;
  assign bus.tx_data  = r_msg[MSG_W-1 -: 8];
  assign bus.busy     = r_busy;
  assign bus.src      = r_src;
  assign bus.msg_done = r_msg_done;

endmodule
